// File: rtl/qu_common.sv
// Shared types for the issue queue: renamed uop cell layout and slot address.
package qu_common;
    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int RS_DEPTH          = 8;
    localparam int RS_DATA_WIDTH     = 32;
    localparam int UOP_WIDTH         = 8;

    typedef logic [$clog2(RS_DEPTH)-1:0] res_st_addr_t;

    typedef struct packed {
        logic [UOP_WIDTH-1:0]         uop;
        logic [PHY_RF_ADDR_WIDTH-1:0] rs1_tag;
        logic                         rs1_ready;
        logic [RS_DATA_WIDTH-1:0]     rs1_data;
        logic [PHY_RF_ADDR_WIDTH-1:0] rs2_tag;
        logic                         rs2_ready;
        logic [RS_DATA_WIDTH-1:0]     rs2_data;
        logic [PHY_RF_ADDR_WIDTH-1:0] rd_tag;
    } res_st_cell_t;
endpackage

// File: rtl/rs_select.sv
// Combinational lowest-index priority encoder: first set bit of req and whether any was set.
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downwards so the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[$clog2(N)-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/res_station.sv
// Reservation station: holds renamed uops until both operands arrive (CDB wakeup/bypass),
// then issues the lowest-index ready entry through a registered valid/ready output.
module res_station #(
    parameter int RS_DEPTH   = qu_common::RS_DEPTH,
    parameter int TAG_WIDTH  = qu_common::PHY_RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = qu_common::RS_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [$clog2(RS_DEPTH)-1:0]   wr_addr,
    input  qu_common::res_st_cell_t       wr_data,
    output logic [$clog2(RS_DEPTH)-1:0]   free_addr,
    output logic                          full,
    output logic [$clog2(RS_DEPTH):0]     count,
    output logic                          wr_err,
    input  logic                          cdb_valid,
    input  logic [TAG_WIDTH-1:0]          cdb_tag,
    input  logic [DATA_WIDTH-1:0]         cdb_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output qu_common::res_st_cell_t       issue_data
);
    import qu_common::*;

    localparam int AW = $clog2(RS_DEPTH);
    localparam int CW = AW + 1;

    res_st_cell_t       cells_q [RS_DEPTH];
    res_st_cell_t       cells_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid_q, valid_d, ready_vec;
    logic [CW-1:0]      count_q, count_d;
    logic               wr_err_q, wr_err_d;
    logic               issue_valid_q, issue_valid_d;
    res_st_cell_t       issue_data_q, issue_data_d;
    logic [AW-1:0]      free_idx, pick_idx;
    logic               free_found, pick_found;
    logic               load, issue_fire, wr_ok;

    // Capture the CDB value into any still-waiting operand whose tag matches.
    function automatic res_st_cell_t snoop(input res_st_cell_t c, input logic hit_v,
                                           input logic [TAG_WIDTH-1:0] tag,
                                           input logic [DATA_WIDTH-1:0] data);
        res_st_cell_t r;
        r = c;
        if (hit_v && !c.rs1_ready && c.rs1_tag == tag) begin
            r.rs1_ready = 1'b1;
            r.rs1_data  = data;
        end
        if (hit_v && !c.rs2_ready && c.rs2_tag == tag) begin
            r.rs2_ready = 1'b1;
            r.rs2_data  = data;
        end
        return r;
    endfunction

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && cells_q[i].rs1_ready && cells_q[i].rs2_ready;
        end
    end

    rs_select #(.N(RS_DEPTH)) u_free (.req(~valid_q),  .idx(free_idx), .found(free_found));
    rs_select #(.N(RS_DEPTH)) u_pick (.req(ready_vec), .idx(pick_idx), .found(pick_found));

    assign load       = !issue_valid_q || issue_ready;
    assign issue_fire = load && pick_found;
    // A full station has every slot valid, so this also rejects writes while full.
    assign wr_ok      = wr_en && !valid_q[wr_addr];

    always_comb begin
        valid_d       = valid_q;
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        wr_err_d      = wr_en && !wr_ok;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cells_d[i] = valid_q[i] ? snoop(cells_q[i], cdb_valid, cdb_tag, cdb_data) : cells_q[i];
        end
        if (issue_fire) begin
            valid_d[pick_idx] = 1'b0;
            issue_valid_d     = 1'b1;
            issue_data_d      = cells_q[pick_idx];
        end else if (load) begin
            issue_valid_d = 1'b0;
        end
        // wr_addr is a free slot, so it can never collide with the slot being issued.
        if (wr_ok) begin
            valid_d[wr_addr] = 1'b1;
            cells_d[wr_addr] = snoop(wr_data, cdb_valid, cdb_tag, cdb_data);
        end
        count_d = count_q + CW'(wr_ok) - CW'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q       <= '0;
            count_q       <= '0;
            wr_err_q      <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            wr_err_q      <= wr_err_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end

    // Payload storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        cells_q <= cells_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(count_q) == $countones(valid_q));
        end
    end

    assign free_addr   = free_found ? free_idx : '0;
    assign full        = &valid_q;
    assign count       = count_q;
    assign wr_err      = wr_err_q;
    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
endmodule

// File: doc/res_station.md
Name: res_station

Overview:
- Reservation station directly downstream of the front end. It accepts renamed uops (res_st_cell_t) at a caller-chosen slot and holds them until both source operands are available.
- It wakes up waiting operands from the common data bus (CDB) and issues one ready entry per cycle through a registered valid/ready output to the execution unit.
- It reports the lowest free slot, full, and occupancy back to rename.

Parameters:
- RS_DEPTH, 8, number of entries; power of two, at least 2.
- TAG_WIDTH, PHY_RF_ADDR_WIDTH, width of a physical register tag.
- DATA_WIDTH, 32, operand data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  clear all entries and the output register
- wr_en  in  1  write request from rename
- wr_addr  in  $clog2(RS_DEPTH)  target slot (res_st_addr_t)
- wr_data  in  res_st_cell_t  renamed uop with operand tags, ready bits and data
- free_addr  out  $clog2(RS_DEPTH)  lowest-index invalid slot; 0 when full
- full  out  1  all slots valid
- count  out  $clog2(RS_DEPTH)+1  number of valid slots
- wr_err  out  1  one-cycle pulse: write dropped
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_WIDTH  broadcast destination tag
- cdb_data  in  DATA_WIDTH  broadcast value
- issue_valid  out  1  output register holds an issued cell
- issue_ready  in  1  execution unit accepts
- issue_data  out  res_st_cell_t  issued cell, both operands ready

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: all entry valid bits 0; issue_valid=0; issue_data=0; count=0; full=0; free_addr=0; wr_err=0.
- Flush: same effect as reset at the next edge. Flush has priority over write, wakeup and issue in that cycle.
- Write: accepted when wr_en && slot wr_addr is invalid. The entry becomes valid at t+1 and count increments.
  - Write to a valid slot, or write while full, is dropped and wr_err pulses at t+1.
  - No entry state changes on a dropped write.
- Same-cycle bypass on write: if cdb_valid and cdb_tag matches an unready operand tag of wr_data, that operand is stored ready with cdb_data.
- Wakeup: for every valid entry and each unready operand, a tag match with cdb_valid sets the ready bit and captures cdb_data at the next edge. Operands that are already ready are never overwritten.
- Ready entry: valid && rs1_ready && rs2_ready, evaluated on registered state only. A wakeup at t makes the entry selectable at t+1.
- Select and issue:
  - The load condition is (!issue_valid || issue_ready).
  - When it holds and at least one entry is ready, the lowest-index ready entry is copied into the output register. That slot's valid bit is cleared at the same edge and issue_valid becomes 1.
  - When no entry is ready, issue_valid becomes 0 if the previous output was consumed.
  - When the load condition is false, the output register and all entries hold.
- Latency: write of an already-ready uop at t gives issue_valid at t+2. A wakeup at t gives issue_valid at t+2, provided the output path is free.
- Simultaneous write and issue in one cycle: legal, and count is net unchanged. Writing the slot being issued in the same cycle is impossible because free_addr reflects pre-edge state.
- Output signals:
  - free_addr and full are combinational from registered valid bits.
  - count is a registered counter. Implementation asserts that count equals the popcount of valid bits.
- issue_data is stable while issue_valid && !issue_ready.

Decomposition:
- Shared package (qu_common): res_st_cell_t fields (uop control, rs1_tag/rs1_ready/rs1_data, rs2_tag/rs2_ready/rs2_data, rd_tag), res_st_addr_t, RS_DEPTH.
- One sub-module: rs_select, a combinational lowest-index priority encoder returning index and found. It is reused for both free_addr and ready selection.

Test Plan:
- Write a ready uop (rs1/rs2 ready, data 5/7) to slot 0 with issue_ready=1 -> issue_valid=1 two cycles later, issue_data operands 5/7, count back to 0.
- Write a uop to slot 2 with rs1_tag=9 unready; CDB tag 9 with data 0x1234 after 3 cycles -> issues at CDB+2 with rs1_data=0x1234.
- Same-cycle write with rs2_tag=4 unready and CDB tag 4 with data 0xAB -> issues with rs2_data=0xAB, no extra wakeup needed.
- Fill all 8 slots -> full=1, count=8, free_addr=0; a further write -> wr_err pulse, no state change.
- Ready entries in slots 1, 3, 6 with issue_ready held 0 for 4 cycles -> slot 1 held stable in issue_data; then 3 and 6 issue on consecutive cycles once issue_ready=1.
- Flush asserted together with a write and a CDB match -> next cycle count=0, issue_valid=0, full=0.
